first_system_sequencer: RTL

FIRST_SYSTEM_SEQUENCER -- requirements
Module: first_system_sequencer

---
 rtl/first_system_sequencer_pkg.sv | 22 ++
 rtl/first_system_sequencer_if.sv | 24 ++
 rtl/first_system_sequencer_hold.sv | 29 ++
 rtl/first_system_sequencer.sv | 109 ++++++++++
 4 files changed

// File: rtl/first_system_sequencer_pkg.sv
// Shared types for the first_system sweep sequencer.
// Holds the FSM state encoding and the vector count.
package first_system_pkg;

    localparam int NUM_VECTORS = 4;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_t;

    // Expected {out1,out2} pair for one input vector.
    function automatic logic [1:0] exp_pair(
        input logic [3:0] e1,
        input logic [3:0] e2,
        input logic [1:0] i
    );
        return {e1[i], e2[i]};
    endfunction

endpackage

// File: rtl/first_system_sequencer_if.sv
// Link between the sequencer and the controlled first_system.
// The master drives the input pair and reads back the outputs.
interface first_system_sequencer_if;

    logic sys_in1;
    logic sys_in2;
    logic sys_out1;
    logic sys_out2;

    modport master (
        output sys_in1,
        output sys_in2,
        input  sys_out1,
        input  sys_out2
    );

    modport slave (
        input  sys_in1,
        input  sys_in2,
        output sys_out1,
        output sys_out2
    );

endinterface

// File: rtl/first_system_sequencer_hold.sv
// Modulo-MAX cycle counter timing how long each vector is held.
// last is high on the final cycle of each hold window.
module hold_counter #(
    parameter int MAX = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int W = (MAX > 1) ? $clog2(MAX) : 1;
    localparam logic [W-1:0] TOP = W'(MAX - 1);

    logic [W-1:0] count;

    assign last = (count == TOP);

    // Count enabled cycles, wrapping to zero after the last one.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/first_system_sequencer.sv
// Sweeps all four input vectors through first_system and
// captures/compares its outputs against expected patterns.
module first_system_sequencer
    import first_system_pkg::*;
#(
    parameter int         HOLD_CYCLES = 100,
    parameter logic [3:0] EXP_OUT1    = 4'b1000,
    parameter logic [3:0] EXP_OUT2    = 4'b0110
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    first_system_sequencer_if.master  sys,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [1:0]                vec_idx,
    output logic [7:0]                result,
    output logic [3:0]                fail_mask
);

    state_t     state;
    state_t     state_nx;
    logic       accept;
    logic       sample;
    logic       last;
    logic       last_vec;
    logic       cnt_clr;
    logic       cnt_en;
    logic [1:0] pair;

    assign last_vec = (vec_idx == 2'(NUM_VECTORS - 1));
    assign pair     = {sys.sys_out1, sys.sys_out2};

    assign cnt_en  = (state == DRIVE);
    assign cnt_clr = (state != DRIVE) || abort;

    hold_counter #(
        .MAX (HOLD_CYCLES)
    ) u_hold (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .last  (last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state; abort beats start, start is ignored mid-sweep.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        sample   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start && !abort) begin
                    accept   = 1'b1;
                    state_nx = DRIVE;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (last) begin
                    sample = 1'b1;
                    if (last_vec) begin
                        state_nx = DONE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Vector index, capture slots and mismatch flags.
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            vec_idx   <= '0;
            result    <= '0;
            fail_mask <= '0;
        end else if (state == DRIVE && abort) begin
            vec_idx <= '0;
        end else if (sample) begin
            result[{vec_idx, 1'b0} +: 2] <= pair;
            if (pair != exp_pair(EXP_OUT1, EXP_OUT2, vec_idx)) begin
                fail_mask[vec_idx] <= 1'b1;
            end
            vec_idx <= vec_idx + 2'd1;
        end
    end

    // vec_idx is zero outside DRIVE, so it doubles as the drive pair.
    assign sys.sys_in1 = vec_idx[1];
    assign sys.sys_in2 = vec_idx[0];

    assign busy = (state == DRIVE);
    assign done = (state == DONE);
    assign pass = done && (fail_mask == 4'h0);

endmodule
